uart_controller: RTL

- Bus slave that gives the CPU access to the board serial port. It sits behind the bus decoder at the UART address prefix.
- It converts single-cycle register reads and writes into 8N1 serial frames on txd, and samples serial frames on rxd.
- Register window is 2 words: offset 0x0 is DATA, offset 0x4 is STATUS. Only address[2] is decoded; address[1:0] is ignored.

---
 rtl/uart_controller_pkg.sv | 15 +
 rtl/uart_controller_if.sv | 22 ++
 rtl/uart_controller_receiver.sv | 106 ++++++++++
 rtl/uart_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_controller_pkg.sv
// Register map, status bit positions and serial FSM states shared by the UART
// top level and its receiver.
package uart_controller_pkg;

  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  localparam int TX_READY  = 0;
  localparam int RX_VALID  = 1;
  localparam int OVERRUN   = 2;
  localparam int FRAME_ERR = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} UartState_t;

endpackage

// File: rtl/uart_controller_if.sv
// Single-cycle CPU bus port of the UART: strobed read/write with combinational read data.
// No backpressure; stall is always low and every access completes in its own cycle.
interface uart_controller_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic        stall;
  logic [31:0] data_rd;
  logic [31:0] data_rd_2;

  modport master (
    output address, read, write, data_wr, mask,
    input  stall, data_rd, data_rd_2
  );

  modport slave (
    input  address, read, write, data_wr, mask,
    output stall, data_rd, data_rd_2
  );
endinterface

// File: rtl/uart_controller_receiver.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling, registered 1-cycle byte/error strobes.
// Latency: byte_strobe rises one cycle after the stop-bit sample; it cannot be backpressured.
module uart_receiver
  import uart_controller_pkg::*;
#(
  parameter int DIV = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_strobe,
  output logic [7:0] data_byte,
  output logic       frame_err_strobe
);
  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

  logic          rxd_meta, rxd_s, rxd_prev;
  UartState_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          err_hold, err_hold_n;
  logic          byte_strobe_n, frame_err_strobe_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta         <= 1'b1;
      rxd_s            <= 1'b1;
      rxd_prev         <= 1'b1;
      state            <= IDLE;
      cnt              <= '0;
      idx              <= '0;
      shreg            <= '0;
      err_hold         <= 1'b0;
      byte_strobe      <= 1'b0;
      frame_err_strobe <= 1'b0;
    end else begin
      rxd_meta         <= rxd;
      rxd_s            <= rxd_meta;
      rxd_prev         <= rxd_s;
      state            <= state_n;
      cnt              <= cnt_n;
      idx              <= idx_n;
      shreg            <= shreg_n;
      err_hold         <= err_hold_n;
      byte_strobe      <= byte_strobe_n;
      frame_err_strobe <= frame_err_strobe_n;
    end
  end

  // START doubles as the half-bit wait so every later sample lands mid-bit.
  always_comb begin
    state_n            = state;
    cnt_n              = cnt + 1'b1;
    idx_n              = idx;
    shreg_n            = shreg;
    err_hold_n         = err_hold;
    byte_strobe_n      = 1'b0;
    frame_err_strobe_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rxd_prev && !rxd_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rxd_s, shreg[7:1]};
          idx_n   = idx + 1'b1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (err_hold) begin
          cnt_n = '0;
          if (rxd_s) begin
            err_hold_n = 1'b0;
            state_n    = IDLE;
          end
        end else if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxd_s) begin
            byte_strobe_n = 1'b1;
            state_n       = IDLE;
          end else begin
            frame_err_strobe_n = 1'b1;
            err_hold_n         = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign data_byte = shreg;

endmodule

// File: rtl/uart_controller.sv
// CPU-bus UART: DATA/STATUS registers, TX FIFO + 8N1 transmitter, RX via uart_receiver.
// Zero-wait bus (stall=0); full-FIFO writes are dropped, so software polls tx_ready.
module uart_controller
  import uart_controller_pkg::*;
#(
  parameter int CLK_FREQ      = 11059200,
  parameter int BAUD          = 115200,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_controller_if.slave  bus,
  output logic              txd,
  input  logic              rxd
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;
  localparam int PW  = $clog2(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(TX_FIFO_DEPTH);

  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_full, fifo_empty, push, pop;

  UartState_t    tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_shreg, tx_shreg_n;
  logic          txd_n;

  logic          rx_valid, overrun, frame_err;
  logic [7:0]    rx_byte, rx_data_byte;
  logic          byte_strobe, frame_err_strobe;
  logic          rd_data, rd_status, wr_data;
  logic          unused_bits;

  assign rd_data   = bus.read  && (bus.address[2] == UART_REG_DATA);
  assign rd_status = bus.read  && (bus.address[2] == UART_REG_STATUS);
  assign wr_data   = bus.write && (bus.address[2] == UART_REG_DATA) && bus.mask[0];

  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = wr_data && (!fifo_full || pop);

  assign bus.stall     = 1'b0;
  assign bus.data_rd_2 = '0;
  assign unused_bits   = ^{bus.address[31:3], bus.address[1:0], bus.data_wr[31:8], bus.mask[3:1]};

  always_comb begin
    bus.data_rd = '0;
    if (rd_status) begin
      bus.data_rd[TX_READY]  = !fifo_full;
      bus.data_rd[RX_VALID]  = rx_valid;
      bus.data_rd[OVERRUN]   = overrun;
      bus.data_rd[FRAME_ERR] = frame_err;
    end else if (rd_data && rx_valid) begin
      bus.data_rd[7:0] = rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.data_wr[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shreg <= tx_shreg_n;
      txd      <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_shreg_n = tx_shreg;
    pop        = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shreg_n = fifo_mem[rd_ptr];
          tx_state_n = START;
        end
      end
      START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_state_n = DATA;
        end
      end
      DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = tx_idx + 1'b1;
          tx_shreg_n = tx_shreg >> 1;
          if (tx_idx == 3'd7) tx_state_n = STOP;
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = IDLE;
        end
      end
      default: tx_state_n = IDLE;
    endcase
    // txd is registered from the next state so the line never glitches.
    case (tx_state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = tx_shreg_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (byte_strobe) begin
        rx_byte  <= rx_data_byte;
        rx_valid <= 1'b1;
      end else if (rd_data && rx_valid) begin
        rx_valid <= 1'b0;
      end
      if (rd_status) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      // A new event in the clearing cycle must not be lost.
      if (byte_strobe && rx_valid && !rd_data) overrun <= 1'b1;
      if (frame_err_strobe) frame_err <= 1'b1;
    end
  end

  uart_receiver #(.DIV(DIV)) u_rx (
    .clk              (clk),
    .rst_n            (rst_n),
    .rxd              (rxd),
    .byte_strobe      (byte_strobe),
    .data_byte        (rx_data_byte),
    .frame_err_strobe (frame_err_strobe)
  );

endmodule
